// File: rtl/tinyriscv_pkg.sv
// Shared memory-bus widths and the RAM arbiter state type.
// MemAddrBus / MemBus : byte-address and data widths of the data RAM bus.
// arb_state_e         : ARB (round-robin) or LOCKED (exclusive owner).
// rr_wrap             : (base + off) mod n for round-robin index arithmetic.
package tinyriscv_pkg;

  localparam int unsigned MemAddrBus = 32;
  localparam int unsigned MemBus     = 32;

  typedef enum logic {
    ARB,
    LOCKED
  } arb_state_e;

  // Assumes base < n and off <= n, so a single subtraction wraps.
  function automatic int unsigned rr_wrap(input int unsigned base,
                                          input int unsigned off,
                                          input int unsigned n);
    int unsigned sum;
    sum = base + off;
    if (sum >= n) sum = sum - n;
    return sum;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker, reusable for any shared resource.
// Ports:
//   req   in  N         : request vector
//   ptr   in  $clog2(N) : highest-priority index for this search
//   gnt   out N         : one-hot grant, all zero when nothing requests
//   idx   out $clog2(N) : granted index (0 when valid is low)
//   valid out 1         : some request was granted
module rr_pick
  import tinyriscv_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 valid
);

  localparam int unsigned IdxW = $clog2(N);

  // Walk N positions starting at ptr; the first requester found wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int unsigned off = 0; off < N; off++) begin
      if (!valid && req[rr_wrap(32'(ptr), off, N)]) begin
        valid = 1'b1;
        idx   = IdxW'(rr_wrap(32'(ptr), off, N));
        gnt[rr_wrap(32'(ptr), off, N)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbiter sharing a single-port data RAM among NumReq bus masters.
// Same-cycle round-robin grant, optional bounded lock for atomic
// read-modify-write sequences, registered read data one cycle after grant.
// Ports:
//   clk_i, rst_i           : clock, synchronous active-high reset
//   req_i/we_i/lock_i      : per-master request, write enable, keep-grant
//   addr_i/wdata_i         : per-master byte address and write data
//   gnt_o                  : one-hot grant (combinational)
//   rvalid_o/rdata_o       : one-hot read response valid, shared read data
//   ram_we_o/ram_addr_o/ram_wdata_o : RAM drive, zero when idle
//   ram_rdata_i            : RAM combinational read data
module ram_arbiter
  import tinyriscv_pkg::*;
#(
  parameter int unsigned NumReq  = 2,
  parameter int unsigned MaxLock = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumReq-1:0]                    req_i,
  input  logic [NumReq-1:0]                    we_i,
  input  logic [NumReq-1:0]                    lock_i,
  input  logic [NumReq-1:0][MemAddrBus-1:0]    addr_i,
  input  logic [NumReq-1:0][MemBus-1:0]        wdata_i,
  output logic [NumReq-1:0]                    gnt_o,
  output logic [NumReq-1:0]                    rvalid_o,
  output logic [MemBus-1:0]                    rdata_o,
  output logic                                 ram_we_o,
  output logic [MemAddrBus-1:0]                ram_addr_o,
  output logic [MemBus-1:0]                    ram_wdata_o,
  input  logic [MemBus-1:0]                    ram_rdata_i
);

  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned CntW = $clog2(MaxLock + 1);

  arb_state_e      state;
  logic [IdxW-1:0] owner;
  logic [IdxW-1:0] ptr;
  logic [CntW-1:0] lock_cnt;

  logic [NumReq-1:0] pick_gnt;
  logic [IdxW-1:0]   pick_idx;
  logic              pick_valid;

  logic [IdxW-1:0]   gidx;
  logic              gvalid;
  logic [CntW-1:0]   cnt_inc;
  logic [IdxW-1:0]   gidx_next;
  logic [IdxW-1:0]   owner_next;

  rr_pick #(
    .N (NumReq)
  ) u_pick (
    .req   (req_i),
    .ptr   (ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Grant selection and RAM drive: the picker is bypassed while locked.
  always_comb begin
    gnt_o  = '0;
    gidx   = '0;
    gvalid = 1'b0;
    if (state == LOCKED) begin
      if (req_i[owner]) begin
        gnt_o[owner] = 1'b1;
        gidx         = owner;
        gvalid       = 1'b1;
      end
    end else begin
      gnt_o  = pick_gnt;
      gidx   = pick_idx;
      gvalid = pick_valid;
    end

    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (gvalid) begin
      ram_we_o    = we_i[gidx];
      ram_addr_o  = addr_i[gidx];
      ram_wdata_o = wdata_i[gidx];
    end
  end

  assign cnt_inc    = lock_cnt + CntW'(1);
  assign gidx_next  = IdxW'(rr_wrap(32'(gidx), 1, NumReq));
  assign owner_next = IdxW'(rr_wrap(32'(owner), 1, NumReq));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ARB;
      owner    <= '0;
      ptr      <= '0;
      lock_cnt <= '0;
      rvalid_o <= '0;
      rdata_o  <= '0;
    end else begin
      // Read response: one-cycle pulse, data held until the next read.
      rvalid_o <= '0;
      if (gvalid && !we_i[gidx]) begin
        rvalid_o[gidx] <= 1'b1;
        rdata_o        <= ram_rdata_i;
      end

      unique case (state)
        ARB: begin
          if (gvalid) begin
            ptr <= gidx_next;
            if (lock_i[gidx] && (MaxLock > 1)) begin
              state    <= LOCKED;
              owner    <= gidx;
              lock_cnt <= CntW'(1);
            end
          end
        end
        LOCKED: begin
          // Release on owner drop, unlocked last access, or count limit;
          // the count includes this granted cycle.
          if (!req_i[owner] || !lock_i[owner] || cnt_inc >= CntW'(MaxLock)) begin
            state    <= ARB;
            ptr      <= owner_next;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= cnt_inc;
          end
        end
        default: begin
          state <= ARB;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed testbench for ram_arbiter with a behavioural word RAM.
module tb_ram_arbiter;
  import tinyriscv_pkg::*;

  logic                          clk;
  logic                          rst;
  logic [1:0]                    req;
  logic [1:0]                    we;
  logic [1:0]                    lock;
  logic [1:0][MemAddrBus-1:0]    addr;
  logic [1:0][MemBus-1:0]        wdata;
  logic [1:0]                    gnt;
  logic [1:0]                    rvalid;
  logic [MemBus-1:0]             rdata;
  logic                          ram_we;
  logic [MemAddrBus-1:0]         ram_addr;
  logic [MemBus-1:0]             ram_wdata;
  logic [MemBus-1:0]             ram_rdata;

  logic [31:0] mem [256];

  int unsigned n_checks;
  int unsigned n_fail;

  ram_arbiter #(
    .NumReq  (2),
    .MaxLock (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .we_i        (we),
    .lock_i      (lock),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .gnt_o       (gnt),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  assign ram_rdata = mem[ram_addr[9:2]];

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[9:2]] <= ram_wdata;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req   = '0;
    we    = '0;
    lock  = '0;
    addr  = '0;
    wdata = '0;
  endtask

  initial begin
    int unsigned c0;
    int unsigned c1;
    n_checks = 0;
    n_fail   = 0;
    idle();
    rst = 1'b1;
    tick();
    tick();

    // Reset state
    check_eq("rst_rvalid", 32'(rvalid), 32'h0);
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_gnt", 32'(gnt), 32'h0);
    check_eq("rst_ram_we", 32'(ram_we), 32'h0);
    check_eq("rst_ram_addr", ram_addr, 32'h0);
    check_eq("rst_ram_wdata", ram_wdata, 32'h0);
    rst = 1'b0;

    // Single read: preload 0x10 through the arbiter, then read it back
    req = 2'b01; we = 2'b01; addr[0] = 32'h10; wdata[0] = 32'hDEADBEEF;
    #1;
    check_eq("wr_gnt", 32'(gnt), 32'h1);
    check_eq("wr_ram_we", 32'(ram_we), 32'h1);
    check_eq("wr_ram_addr", ram_addr, 32'h10);
    check_eq("wr_ram_wdata", ram_wdata, 32'hDEADBEEF);
    tick();
    we = 2'b00;
    #1;
    check_eq("rd_gnt", 32'(gnt), 32'h1);
    check_eq("rd_ram_we", 32'(ram_we), 32'h0);
    check_eq("wr_no_rvalid", 32'(rvalid), 32'h0);
    tick();
    idle();
    #1;
    check_eq("rd_rvalid", 32'(rvalid), 32'h1);
    check_eq("rd_rdata", rdata, 32'hDEADBEEF);
    check_eq("rd_idle_gnt", 32'(gnt), 32'h0);
    check_eq("rd_idle_addr", ram_addr, 32'h0);
    tick();
    check_eq("rd_rvalid_pulse", 32'(rvalid), 32'h0);
    check_eq("rd_rdata_hold", rdata, 32'hDEADBEEF);

    // Contention after reset: alternating writes
    rst = 1'b1;
    tick();
    rst = 1'b0;
    c0 = 0;
    c1 = 0;
    req = 2'b11; we = 2'b11;
    for (int i = 0; i < 6; i++) begin
      addr[0]  = 32'h100 + 4 * c0;
      wdata[0] = 32'hA000_0000 + c0;
      addr[1]  = 32'h200 + 4 * c1;
      wdata[1] = 32'hB000_0000 + c1;
      #1;
      check_eq($sformatf("alt_gnt%0d", i), 32'(gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
      check_eq($sformatf("alt_rvalid%0d", i), 32'(rvalid), 32'h0);
      tick();
      if (i % 2 == 0) c0++;
      else            c1++;
    end
    idle();
    for (int j = 0; j < 3; j++) begin
      check_eq($sformatf("alt_mem0_%0d", j), mem[64 + j], 32'hA000_0000 + j);
      check_eq($sformatf("alt_mem1_%0d", j), mem[128 + j], 32'hB000_0000 + j);
    end

    // Lock sequence: master 1 locked read, then unlocked write
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 2'b01; we = 2'b01; addr[0] = 32'h40; wdata[0] = 32'h1;
    tick();
    req = 2'b11; we = 2'b01; lock = 2'b10;
    addr[0] = 32'h300; wdata[0] = 32'h55; addr[1] = 32'h10;
    #1;
    check_eq("lk_gnt_a", 32'(gnt), 32'h2);
    check_eq("lk_addr_a", ram_addr, 32'h10);
    tick();
    we = 2'b11; lock = 2'b00; addr[1] = 32'h20; wdata[1] = 32'h1234;
    #1;
    check_eq("lk_gnt_b", 32'(gnt), 32'h2);
    check_eq("lk_rvalid_b", 32'(rvalid), 32'h2);
    check_eq("lk_rdata_b", rdata, 32'hDEADBEEF);
    tick();
    req = 2'b01;
    #1;
    check_eq("lk_gnt_c", 32'(gnt), 32'h1);
    check_eq("lk_addr_c", ram_addr, 32'h300);
    check_eq("lk_rvalid_c", 32'(rvalid), 32'h0);
    tick();
    idle();
    #1;
    check_eq("lk_gnt_d", 32'(gnt), 32'h0);
    check_eq("lk_mem_m1", mem[8], 32'h1234);
    check_eq("lk_mem_m0", mem[192], 32'h55);

    // Forced release at MaxLock = 4, then relock as sole requester
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 2'b11; we = 2'b10; lock = 2'b01;
    addr[0] = 32'h10; addr[1] = 32'h80; wdata[1] = 32'h77;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq($sformatf("fr_gnt%0d", i), 32'(gnt), (i < 4) ? 32'h1 : 32'h2);
      if (i > 0) check_eq($sformatf("fr_rvalid%0d", i), 32'(rvalid), 32'h1);
      tick();
    end
    req = 2'b01;
    #1;
    check_eq("fr_relock_gnt", 32'(gnt), 32'h1);
    check_eq("fr_wr_no_rvalid", 32'(rvalid), 32'h0);
    check_eq("fr_mem", mem[32], 32'h77);
    tick();
    req = 2'b11;
    #1;
    check_eq("fr_relocked", 32'(gnt), 32'h1);
    tick();
    idle();

    // Reset after a granted read drops the response data
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 2'b01; addr[0] = 32'h10;
    #1;
    check_eq("rr_gnt", 32'(gnt), 32'h1);
    tick();
    idle();
    rst = 1'b1;
    #1;
    check_eq("rr_rvalid_pre", 32'(rvalid), 32'h1);
    tick();
    check_eq("rr_rvalid", 32'(rvalid), 32'h0);
    check_eq("rr_rdata", rdata, 32'h0);
    rst = 1'b0;

    // Reset while LOCKED: next grant follows ptr = 0
    req = 2'b01; we = 2'b01; addr[0] = 32'h44; wdata[0] = 32'h2;
    tick();
    req = 2'b10; we = 2'b00; lock = 2'b10; addr[1] = 32'h10;
    #1;
    check_eq("rl_gnt_enter", 32'(gnt), 32'h2);
    tick();
    req = 2'b11; we = 2'b00;
    #1;
    check_eq("rl_gnt_locked", 32'(gnt), 32'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_eq("rl_gnt_after", 32'(gnt), 32'h1);
    tick();
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single-port data RAM among `NumReq` bus masters, for example the core load/store unit and the debug/DMA port. It provides a same-cycle grant with round-robin fairness. A lock lets one master run an atomic read-modify-write sequence, bounded to a fixed length. Read data is registered and returned one cycle after the grant. The block sits between the masters and the RAM, and drives the RAM's write enable, address and write-data inputs.

## Interface
- `NumReq`, default 2: number of requesters; must be ≥ 2.
- `MaxLock`, default 16: maximum number of consecutive granted cycles one locked owner may hold; must be ≥ 2.
- `clk_i`  in  1: clock.
- `rst_i`  in  1: reset, **synchronous, active-high**.
- `req_i`  in  NumReq: per-master access request.
- `we_i`  in  NumReq: per-master write enable (1 = write).
- `lock_i`  in  NumReq: per-master request to keep the grant after this access.
- `addr_i`  in  NumReq×MemAddrBus: per-master byte address.
- `wdata_i`  in  NumReq×MemBus: per-master write data.
- `gnt_o`  out  NumReq: one-hot grant; all zero when no master is granted.
- `rvalid_o`  out  NumReq: one-hot read response valid.
- `rdata_o`  out  MemBus: read data, shared by all masters; qualified by `rvalid_o`.
- `ram_we_o`  out  1: RAM write enable.
- `ram_addr_o`  out  MemAddrBus: RAM address.
- `ram_wdata_o`  out  MemBus: RAM write data.
- `ram_rdata_i`  in  MemBus: RAM combinational read data.

## Operation
- **States**
  - ARB: normal round-robin.
  - LOCKED: exclusive grant held by master `owner`.
- **Round-robin (ARB)**
  - Grant the first requesting master found searching from `ptr` upward, wrapping modulo `NumReq`.
  - After any grant to master k, set `ptr` to (k+1) mod `NumReq`.
- **RAM drive**
  - The granted master's `addr_i` and `wdata_i` go to `ram_addr_o` and `ram_wdata_o`.
  - `ram_we_o` = `we_i[k]` of the granted master k.
  - With no grant, `ram_we_o`=0, `ram_addr_o`=0 and `ram_wdata_o`=0.
- **Reads**
  - On a granted read, capture `ram_rdata_i` into `rdata_o` at the clock edge.
  - Pulse `rvalid_o[k]` for exactly the following cycle.
  - `rdata_o` holds its value until the next read response.
- **Writes**
  - A write completes on the grant cycle.
  - No `rvalid` is issued for a write.
- **Lock entry**
  - Condition: master k is granted in ARB with `lock_i[k]`=1 and `MaxLock` > 1.
  - Action: move to LOCKED with `owner`=k and `lock_cnt`=1.
- **LOCKED**
  - `gnt_o[owner]` = `req_i[owner]`; all other grants are 0.
  - Each granted owner cycle increments `lock_cnt`.
- **Lock exit** to ARB, with `ptr`=(owner+1) mod `NumReq`, on any of these:
  - the owner is granted with `lock_i[owner]`=0 (that access is the last one);
  - `req_i[owner]`=0 (no grant that cycle);
  - `lock_cnt` reaches `MaxLock` on a granted cycle (forced release).
- **After release**
  - The next arbitration runs as ARB from the new `ptr`.
  - A former owner that still asserts `lock_i` competes normally.
  - If it is the only requester, it may relock immediately.
- `lock_cnt` width is $clog2(MaxLock+1) and it never wraps.

## Timing
- `gnt_o` and the `ram_*` outputs are combinational from the inputs and the registered state (`state`, `owner`, `ptr`, `lock_cnt`).
- Read latency is 1 cycle from grant to `rvalid_o`/`rdata_o`.
- Back-to-back grants are allowed every cycle, including alternating masters.
- A master must hold `req_i`, `we_i`, `addr_i` and `wdata_i` stable until the cycle in which it is granted.
- Reset values:
  - state=ARB, `ptr`=0, `owner`=0, `lock_cnt`=0;
  - `rvalid_o`=0, `rdata_o`=0;
  - `gnt_o`=0 whenever `req_i`=0.
- Reset asserted while a read is outstanding: the response is dropped and `rvalid_o` is 0 in the following cycle.
- Reset asserted while LOCKED: return to ARB, and the lock is not retained.
- Simultaneous requests from all masters with `ptr` at the last index: the last master wins, then `ptr` wraps to 0.

## Structure
- `tinyriscv_pkg` supplies `MemAddrBus` and `MemBus`.
- Add to the package: an `arb_state_e` enum (ARB, LOCKED).
- Sub-module `rr_pick`: purely combinational. It takes `req` plus `ptr` and produces a one-hot grant plus the granted index. It is reused for other shared resources.
- All sequential state (`state`, `owner`, `ptr`, `lock_cnt`, `rdata_o`, `rvalid_o`) lives in `ram_arbiter`.

## Test plan
- **Single read:** master 0 reads address 0x10, which holds 0xDEADBEEF → `gnt_o`=01 at cycle t; at t+1, `rvalid_o`=01 and `rdata_o`=0xDEADBEEF.
- **Contention after reset:** both masters write continuously → grants alternate 01, 10, 01, 10, …; every accepted write lands in the RAM.
- **Lock sequence:** master 1 reads with lock, then writes with `lock_i`=0, while master 0 requests throughout → master 0 is granted only on the cycle after master 1's unlocked write.
- **Forced release:** `MaxLock`=4, master 0 holds `lock_i`=1 and `req_i`=1, and master 1 requests → master 0 is granted 4 consecutive cycles, then master 1 is granted on the 5th.
- **Reset mid-operation:**
  - Assert `rst_i` in the cycle after a granted read → `rvalid_o`=0 and `rdata_o`=0.
  - Assert `rst_i` while LOCKED → the next grant follows `ptr`=0.
